// File: rtl/hwpe_stream_addressgen_3d_lite.sv
// Streaming address generator for 1D/2D/3D strided jobs.
// Emits one address per ready/valid handshake, then pulses done_o for one cycle.
module hwpe_stream_addressgen_3d_lite #(
    parameter int AW = 32,
    parameter int CW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [CW-1:0] tot_len_i,
    input  logic [CW-1:0] d0_len_i,
    input  logic [CW-1:0] d0_stride_i,
    input  logic [CW-1:0] d1_len_i,
    input  logic [CW-1:0] d1_stride_i,
    input  logic [CW-1:0] d2_stride_i,
    input  logic [1:0]    dim_enable_1h_i,
    output logic [AW-1:0] addr_o,
    output logic          addr_valid_o,
    input  logic          addr_ready_i,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    dim;
    logic [CW-1:0] tot_len, d0_len, d1_len;
    logic [AW-1:0] s0, s1, s2;
    logic [CW-1:0] w, d0_idx, d1_idx;
    logic [AW-1:0] line_ptr, block_ptr, addr;
    logic          valid;

    logic          is_2d, is_3d, d0_wrap, d1_wrap, hs;
    logic [AW-1:0] line_nxt, block_nxt;

    assign is_2d     = (dim == 2'b01);
    assign is_3d     = (dim == 2'b11);
    assign d0_wrap   = (is_2d || is_3d) && (d0_idx == d0_len - CW'(1));
    assign d1_wrap   = is_3d && (d1_idx == d1_len - CW'(1));
    assign hs        = valid && addr_ready_i;
    assign line_nxt  = line_ptr + s1;
    assign block_nxt = block_ptr + s2;

    assign addr_o       = addr;
    assign addr_valid_o = valid;
    assign busy_o       = (state == RUN);
    assign done_o       = (state == DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            dim       <= '0;
            tot_len   <= '0;
            d0_len    <= '0;
            d1_len    <= '0;
            s0        <= '0;
            s1        <= '0;
            s2        <= '0;
            w         <= '0;
            d0_idx    <= '0;
            d1_idx    <= '0;
            line_ptr  <= '0;
            block_ptr <= '0;
            addr      <= '0;
            valid     <= 1'b0;
        end else if (clear_i) begin
            state     <= IDLE;
            dim       <= '0;
            tot_len   <= '0;
            d0_len    <= '0;
            d1_len    <= '0;
            s0        <= '0;
            s1        <= '0;
            s2        <= '0;
            w         <= '0;
            d0_idx    <= '0;
            d1_idx    <= '0;
            line_ptr  <= '0;
            block_ptr <= '0;
            addr      <= '0;
            valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    dim       <= dim_enable_1h_i;
                    tot_len   <= tot_len_i;
                    // zero-length dimensions behave as length one
                    d0_len    <= (d0_len_i == '0) ? CW'(1) : d0_len_i;
                    d1_len    <= (d1_len_i == '0) ? CW'(1) : d1_len_i;
                    s0        <= AW'($signed(d0_stride_i));
                    s1        <= AW'($signed(d1_stride_i));
                    s2        <= AW'($signed(d2_stride_i));
                    w         <= '0;
                    d0_idx    <= '0;
                    d1_idx    <= '0;
                    line_ptr  <= base_addr_i;
                    block_ptr <= base_addr_i;
                    addr      <= base_addr_i;
                    if (tot_len_i == '0) begin
                        state <= DONE;
                    end else begin
                        state <= RUN;
                        valid <= 1'b1;
                    end
                end
                RUN: if (hs) begin
                    w <= w + CW'(1);
                    if (w + CW'(1) == tot_len) begin
                        state <= DONE;
                        valid <= 1'b0;
                    end
                    if (!d0_wrap) begin
                        d0_idx <= d0_idx + CW'(1);
                        addr   <= addr + s0;
                    end else if (!d1_wrap) begin
                        d0_idx   <= '0;
                        d1_idx   <= d1_idx + CW'(1);
                        line_ptr <= line_nxt;
                        addr     <= line_nxt;
                    end else begin
                        d0_idx    <= '0;
                        d1_idx    <= '0;
                        block_ptr <= block_nxt;
                        line_ptr  <= block_nxt;
                        addr      <= block_nxt;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_stream_addressgen_3d_lite.sv
// Directed bench for the 3D address generator: stream order, backpressure,
// zero-length jobs, clear and asynchronous reset.
module tb_hwpe_stream_addressgen_3d_lite;

    logic        clk = 1'b0;
    logic        rst, clear, start, ready;
    logic [31:0] base, tot, d0l, d0s, d1l, d1s, d2s;
    logic [1:0]  dim;
    logic [31:0] addr;
    logic        valid, busy, done;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ev[$];

    hwpe_stream_addressgen_3d_lite #(.AW(32), .CW(32)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
        .base_addr_i(base), .tot_len_i(tot), .d0_len_i(d0l), .d0_stride_i(d0s),
        .d1_len_i(d1l), .d1_stride_i(d1s), .d2_stride_i(d2s),
        .dim_enable_1h_i(dim), .addr_o(addr), .addr_valid_o(valid),
        .addr_ready_i(ready), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] b, input logic [31:0] t, input logic [31:0] l0,
                             input logic [31:0] st0, input logic [31:0] l1, input logic [31:0] st1,
                             input logic [31:0] st2, input logic [1:0] dm);
        base = b; tot = t; d0l = l0; d0s = st0; d1l = l1; d1s = st1; d2s = st2; dim = dm;
        start = 1'b1;
        tick();
        start = 1'b0;
        base = 32'hDEAD_BEEF; tot = 32'd99; d0s = 32'd7;
    endtask

    // Full-throughput stream of ev[], then the done pulse.
    task automatic expect_stream(input string tag);
        ready = 1'b1;
        for (int i = 0; i < ev.size(); i++) begin
            chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
            chk({tag, "_addr"}, addr, ev[i]);
            tick();
        end
        ready = 1'b0;
        chk({tag, "_end_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int got;
        int cyc;
        rst = 1'b1; clear = 1'b0; start = 1'b0; ready = 1'b0;
        base = '0; tot = '0; d0l = '0; d0s = '0; d1l = '0; d1s = '0; d2s = '0; dim = '0;
        #12;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();

        // 1D
        start_job(32'h1000, 4, 0, 4, 0, 0, 0, 2'b00);
        chk("1d_busy", {31'd0, busy}, 32'd1);
        ev = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        expect_stream("1d");

        // 2D
        start_job(32'h0, 6, 3, 4, 0, 32'h100, 0, 2'b01);
        ev = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108};
        expect_stream("2d");

        // 3D
        start_job(32'h0, 8, 2, 1, 2, 32'h10, 32'h1000, 2'b11);
        ev = '{32'h0, 32'h1, 32'h10, 32'h11, 32'h1000, 32'h1001, 32'h1010, 32'h1011};
        expect_stream("3d");

        // 2D with d0_len = 0 acts as length 1: every step is a line step
        start_job(32'h40, 3, 0, 4, 0, 32'h100, 0, 2'b01);
        ev = '{32'h40, 32'h140, 32'h240};
        expect_stream("2d_len0");

        // dim 10 behaves as 1D
        start_job(32'h20, 3, 1, 8, 1, 32'h100, 32'h1000, 2'b10);
        ev = '{32'h20, 32'h28, 32'h30};
        expect_stream("dim10");

        // backpressure, negative stride wrapping below zero
        start_job(32'h10, 6, 0, 32'hFFFF_FFFC, 0, 0, 0, 2'b00);
        ev = '{32'h10, 32'hC, 32'h8, 32'h4, 32'h0, 32'hFFFF_FFFC};
        got = 0; cyc = 0;
        while (got < 6 && cyc < 200) begin
            ready = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            base = 32'h5555_0000;
            chk("bp_valid", {31'd0, valid}, 32'd1);
            chk("bp_addr", addr, ev[got]);
            if (ready) got++;
            tick();
            cyc++;
        end
        start = 1'b0; ready = 1'b0;
        chk("bp_count", got, 6);
        chk("bp_done", {31'd0, done}, 32'd1);
        chk("bp_end_valid", {31'd0, valid}, 32'd0);
        tick();

        // tot = 0
        ready = 1'b1;
        start_job(32'h300, 0, 0, 4, 0, 0, 0, 2'b00);
        chk("tot0_done", {31'd0, done}, 32'd1);
        chk("tot0_valid", {31'd0, valid}, 32'd0);
        chk("tot0_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("tot0_done_drop", {31'd0, done}, 32'd0);
        chk("tot0_valid2", {31'd0, valid}, 32'd0);
        ready = 1'b0;

        // clear after two handshakes
        start_job(32'h2000, 8, 0, 4, 0, 0, 0, 2'b00);
        ready = 1'b1;
        tick();
        tick();
        chk("clr_pre_addr", addr, 32'h2008);
        ready = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_valid", {31'd0, valid}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_done", {31'd0, done}, 32'd0);
        chk("clr_addr", addr, 32'd0);
        tick();
        chk("clr_done2", {31'd0, done}, 32'd0);
        start_job(32'h500, 2, 0, 2, 0, 0, 0, 2'b00);
        ev = '{32'h500, 32'h502};
        expect_stream("post_clr");

        // async reset mid-job
        start_job(32'h3000, 8, 0, 4, 0, 0, 0, 2'b00);
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_addr", addr, 32'd0);
        tick();
        chk("arst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();
        start_job(32'h700, 3, 2, 1, 0, 32'h80, 0, 2'b01);
        ev = '{32'h700, 32'h701, 32'h780};
        expect_stream("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_addressgen_3d_lite.md
HWPE_STREAM_ADDRESSGEN_3D_LITE -- requirements
Module: hwpe_stream_addressgen_3d_lite

Interface
REQ-001 Parameter AW, default 32: address width of base_addr_i and addr_o.
REQ-002 Parameter CW, default 32: width of all length fields, counters and stride fields.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 clear_i  in  1  synchronous clear; same effect as reset, applied at the next edge.
REQ-007 start_i  in  1  single-cycle request that latches all ctrl inputs and begins a job.
REQ-008 base_addr_i  in  AW  job base address.
REQ-009 tot_len_i  in  CW  total number of addresses to emit.
REQ-010 d0_len_i  in  CW  words per line; used only in 2D/3D.
REQ-011 d0_stride_i  in  CW  signed word stride.
REQ-012 d1_len_i  in  CW  lines per block; used only in 3D.
REQ-013 d1_stride_i  in  CW  signed line stride.
REQ-014 d2_stride_i  in  CW  signed block stride.
REQ-015 dim_enable_1h_i  in  2  00=1D, 01=2D, 11=3D; 10 treated as 1D.
REQ-016 addr_o  out  AW  current address.
REQ-017 addr_valid_o  out  1  addr_o is valid.
REQ-018 addr_ready_i  in  1  consumer accepts addr_o when high together with addr_valid_o.
REQ-019 busy_o  out  1  high while a job is active (RUN state).
REQ-020 done_o  out  1  one-cycle pulse when a job completes.

Function
REQ-021 FSM states: IDLE, RUN, DONE; reset/clear state is IDLE.
REQ-022 IDLE + start_i: all ctrl inputs are latched; if latched tot_len = 0, the FSM goes to DONE, otherwise to RUN with addr_o = base_addr_i.
REQ-023 start_i is ignored in RUN and DONE; latched ctrl values do not change during a job.
REQ-024 In RUN, addr_valid_o = 1; addr_o and addr_valid_o are registered outputs, and addr_o holds stable until handshake.
REQ-025 Handshake = addr_valid_o & addr_ready_i; each handshake increments word counter w, and the next address appears the following cycle; sustained throughput is one address per cycle.
REQ-026 1D: next addr = addr + d0_stride.
REQ-027 2D: while d0 index < d0_len-1, next = addr + d0_stride and d0 index increments; at d0_len-1, d0 index returns to 0, line pointer += d1_stride, and next = new line pointer.
REQ-028 3D: as 2D, but when d0 and d1 both wrap, d1 index returns to 0, block pointer += d2_stride, and line pointer = next = new block pointer.
REQ-029 Arithmetic: strides are sign-extended to AW; additions are modulo 2^AW with no saturation and no error flag.
REQ-030 On the handshake where w reaches tot_len: go to DONE with addr_valid_o = 0 the next cycle.
REQ-031 DONE lasts exactly one cycle with done_o = 1, then the FSM returns to IDLE; busy_o = 0 in IDLE and DONE.
REQ-032 d0_len = 0 or d1_len = 0 in an enabled dimension is treated as 1.
REQ-033 The addr_ready_i value is don't-care while addr_valid_o = 0.
REQ-034 clear_i in any state: IDLE at the next edge; any pending address is dropped and no done_o pulse is produced.

Reset
REQ-035 During rst_i or after clear_i: state = IDLE, addr_o = 0, addr_valid_o = 0, busy_o = 0, done_o = 0, and all counters and pointers are 0.
REQ-036 Reset mid-job aborts immediately and asynchronously; the first start_i after release begins a fresh job.

Verification
REQ-037 1D: base = 0x1000, tot = 4, d0_stride = 4, ready held 1 -> addresses 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles, then done_o pulse.
REQ-038 2D: base = 0, tot = 6, d0_len = 3, d0_stride = 4, d1_stride = 0x100 -> 0, 4, 8, 0x100, 0x104, 0x108.
REQ-039 3D: tot = 8, d0_len = 2, d1_len = 2, d0_stride = 1, d1_stride = 0x10, d2_stride = 0x1000 -> 0, 1, 0x10, 0x11, 0x1000, 0x1001, 0x1010, 0x1011.
REQ-040 Backpressure: random ready with a negative stride (d0_stride = -4 from base 0x10) -> no address is lost or duplicated; addr_o is stable while stalled; wrap below 0 is modulo 2^AW.
REQ-041 tot = 0 -> no valid is ever asserted; done_o is high exactly 1 cycle after start_i.
REQ-042 clear_i after 2 handshakes of an 8-address job, and separately async rst_i -> valid drops, no done_o, busy_o = 0; a new start works correctly.
